grad_mag: RTL and testbench
===========================

GRAD_MAG -- requirements
Module: grad_mag

Interface
REQ-001 Parameter NPIX, default 65279, number of gradient words processed (addresses 0..NPIX-1).
REQ-002 Parameter THRESH, default 64, edge threshold on unsaturated magnitude.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse from the gradient stage's done; begins a frame.
REQ-006 grad_rd  output  1  gradient memory read enable.
REQ-007 grad_addr  output  16  gradient memory read address.
REQ-008 grad_di  input  20  gradient word {gx[19:10], gy[9:0]}, two's complement, valid one cycle after grad_rd.
REQ-009 mag_wr  output  1  magnitude memory write enable.
REQ-010 mag_addr  output  16  magnitude memory write address.
REQ-011 mag_do  output  8  saturated magnitude to write.
REQ-012 edge_cnt  output  16  count of pixels with magnitude >= THRESH in the last frame.
REQ-013 busy  output  1  high from start acceptance until done.
REQ-014 done  output  1  high from frame completion until the next accepted start.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN, FIN; IDLE->RUN on start; RUN->DRAIN after issuing address NPIX-1; DRAIN->FIN when the last write is issued; FIN->RUN on start.
REQ-016 On accepted start: edge_cnt cleared to 0, done cleared, read address counter set to 0 in the same cycle.
REQ-017 RUN: grad_rd=1 every cycle, grad_addr increments by 1 per cycle from 0 to NPIX-1; no bubbles.
REQ-018 Pipeline: read issued cycle k, grad_di captured cycle k+1, mag_wr/mag_addr/mag_do registered and presented cycle k+2; mag_addr equals the grad_addr issued at cycle k.
REQ-019 Magnitude m = |gx| + |gy|, computed in 11 bits unsigned; |-512| = 512 exactly.
REQ-020 mag_do = m if m <= 255, else 255.
REQ-021 edge_cnt increments by 1 for each pixel with m >= THRESH (unsaturated m), saturating at 65535.
REQ-022 Throughput one pixel per cycle; total frame time NPIX+2 cycles from start to done.
REQ-023 done asserts the cycle after the last mag_wr; edge_cnt final and stable while done=1.
REQ-024 start while busy=1 is ignored; no address restart, no counter clear.
REQ-025 start and the final write in the same cycle: final write completes, new start ignored.
REQ-026 grad_rd and mag_wr are 0 in IDLE and FIN; grad_addr/mag_addr hold last values there.

Reset
REQ-027 reset low forces state IDLE and all outputs to 0 (grad_rd, grad_addr, mag_wr, mag_addr, mag_do, edge_cnt, busy, done) immediately, independent of clk.
REQ-028 Reset mid-frame abandons the frame: no further reads or writes until a new start after reset release.

Structure
REQ-029 Shared package holds FSM state encoding, GRAD_W=20, COMP_W=10, ADDR_W=16, MAG_W=8 constants.
REQ-030 One sub-module, grad_abs_sum: combinational {gx,gy} -> 11-bit m plus saturated 8-bit value.

Verification
REQ-031 grad_di gx=3, gy=-4 at address 0 -> mag_addr 0, mag_do 7, two cycles after the read.
REQ-032 gx=-512, gy=-512 -> m=1024, mag_do 255, edge_cnt increments by 1.
REQ-033 Frame with m=THRESH-1 at all pixels except m=THRESH at 10 pixels -> edge_cnt=10 at done.
REQ-034 NPIX=16, start at cycle 0 -> grad_addr 0..15 on cycles 1..16, mag_wr cycles 3..18, done at cycle 19.
REQ-035 Second start pulse at mid-frame -> ignored; addresses continue monotonically, one done only.
REQ-036 reset low at pixel 100 -> all outputs 0 at once; no writes until next start; next frame from address 0 correct.

Source files
------------

// File: rtl/grad_mag_pkg.sv
// Shared constants and FSM encoding for the gradient-magnitude stage.
package grad_mag_pkg;

  localparam int GRAD_W = 20;          // packed {gx, gy}
  localparam int COMP_W = 10;          // one signed gradient component
  localparam int ADDR_W = 16;          // pixel address width
  localparam int MAG_W  = 8;           // saturated magnitude width
  localparam int SUM_W  = COMP_W + 1;  // |gx| + |gy| fits in 11 bits (max 1024)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/grad_abs_sum.sv
// Combinational |gx| + |gy| with an 8-bit saturated copy for the output memory.
module grad_abs_sum
  import grad_mag_pkg::*;
(
  input  logic [GRAD_W-1:0] grad_i,
  output logic [SUM_W-1:0]  mag_o,
  output logic [MAG_W-1:0]  sat_o
);

  localparam logic [SUM_W-1:0] ONE = SUM_W'(1);

  logic [SUM_W-1:0] gx_ext;
  logic [SUM_W-1:0] gy_ext;
  logic [SUM_W-1:0] gx_abs;
  logic [SUM_W-1:0] gy_abs;

  // Sign-extend to 11 bits first so that |-512| = 512 is representable.
  always_comb begin
    gx_ext = {grad_i[GRAD_W-1], grad_i[GRAD_W-1:COMP_W]};
    gy_ext = {grad_i[COMP_W-1], grad_i[COMP_W-1:0]};
    gx_abs = gx_ext[SUM_W-1] ? (~gx_ext + ONE) : gx_ext;
    gy_abs = gy_ext[SUM_W-1] ? (~gy_ext + ONE) : gy_ext;
    mag_o  = gx_abs + gy_abs;
    sat_o  = (|mag_o[SUM_W-1:MAG_W]) ? {MAG_W{1'b1}} : mag_o[MAG_W-1:0];
  end

endmodule

// File: rtl/grad_mag.sv
// Gradient magnitude stage: streams NPIX gradient words from memory, writes the
// saturated |gx|+|gy| back two cycles after each read, and counts edge pixels.
//
// Handshake: there is no backpressure. grad_rd/grad_addr issued in cycle k
// expect grad_di valid in cycle k+1; mag_wr/mag_addr/mag_do are presented in
// cycle k+2 and must be accepted by the magnitude memory in that cycle. start
// is a single-cycle pulse, honoured only when busy is low.
module grad_mag
  import grad_mag_pkg::*;
#(
  parameter int NPIX   = 65279,
  parameter int THRESH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              grad_rd,
  output logic [ADDR_W-1:0] grad_addr,
  input  logic [GRAD_W-1:0] grad_di,
  output logic              mag_wr,
  output logic [ADDR_W-1:0] mag_addr,
  output logic [MAG_W-1:0]  mag_do,
  output logic [15:0]       edge_cnt,
  output logic              busy,
  output logic              done,
  output state_t            state_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [SUM_W-1:0]  THR       = SUM_W'(THRESH);

  state_t            state_q;
  logic              rd_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              v1_q;       // a read issued last cycle has data on grad_di now
  logic [ADDR_W-1:0] a1_q;       // address belonging to that data
  logic              wr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [MAG_W-1:0]  mag_q;
  logic [15:0]       cnt_q;
  logic              busy_q;
  logic              done_q;

  logic [SUM_W-1:0]  mag_sum;
  logic [MAG_W-1:0]  mag_sat;
  logic              last_wr;

  grad_abs_sum u_abs_sum (
    .grad_i (grad_di),
    .mag_o  (mag_sum),
    .sat_o  (mag_sat)
  );

  // Final write is on the output this cycle; the frame completes at the next edge.
  assign last_wr = (state_q == DRAIN) && wr_q && (waddr_q == LAST_ADDR);

  // Control FSM, read address generator and the two-stage write pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      raddr_q <= '0;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      v1_q <= rd_q;
      a1_q <= raddr_q;
      wr_q <= v1_q;
      if (v1_q) begin
        waddr_q <= a1_q;
        mag_q   <= mag_sat;
        if ((mag_sum >= THR) && (cnt_q != 16'hFFFF)) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      case (state_q)
        IDLE, FIN: begin
          // Pipeline is empty here, so clearing the count cannot race an increment.
          if (start) begin
            state_q <= RUN;
            rd_q    <= 1'b1;
            raddr_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (raddr_q == LAST_ADDR) begin
            rd_q    <= 1'b0;
            state_q <= DRAIN;
          end else begin
            raddr_q <= raddr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (last_wr) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grad_rd   = rd_q;
  assign grad_addr = raddr_q;
  assign mag_wr    = wr_q;
  assign mag_addr  = waddr_q;
  assign mag_do    = mag_q;
  assign edge_cnt  = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_grad_mag.sv
// Directed bench for grad_mag: a 16-pixel instance for cycle-exact timing,
// thresholds and start filtering, and a 128-pixel instance for mid-frame reset.
module tb_grad_mag;
  import grad_mag_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (NPIX=16) ----------------
  logic        reset_a, start_a;
  logic        grad_rd_a, mag_wr_a, busy_a, done_a;
  logic [15:0] grad_addr_a, mag_addr_a, edge_cnt_a;
  logic [19:0] grad_di_a = '0;
  logic [7:0]  mag_do_a;
  state_t      state_a;

  grad_mag #(.NPIX(16), .THRESH(64)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a),
    .grad_rd(grad_rd_a), .grad_addr(grad_addr_a), .grad_di(grad_di_a),
    .mag_wr(mag_wr_a), .mag_addr(mag_addr_a), .mag_do(mag_do_a),
    .edge_cnt(edge_cnt_a), .busy(busy_a), .done(done_a), .state_o(state_a)
  );

  // ---------------- DUT B (NPIX=128) ----------------
  logic        reset_b, start_b;
  logic        grad_rd_b, mag_wr_b, busy_b, done_b;
  logic [15:0] grad_addr_b, mag_addr_b, edge_cnt_b;
  logic [19:0] grad_di_b = '0;
  logic [7:0]  mag_do_b;
  state_t      state_b;

  grad_mag #(.NPIX(128), .THRESH(64)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b),
    .grad_rd(grad_rd_b), .grad_addr(grad_addr_b), .grad_di(grad_di_b),
    .mag_wr(mag_wr_b), .mag_addr(mag_addr_b), .mag_do(mag_do_b),
    .edge_cnt(edge_cnt_b), .busy(busy_b), .done(done_b), .state_o(state_b)
  );

  // Synchronous-read gradient memories
  logic [19:0] mem_a [16];
  logic [19:0] mem_b [128];
  always @(posedge clk) if (grad_rd_a) grad_di_a <= mem_a[grad_addr_a[3:0]];
  always @(posedge clk) if (grad_rd_b) grad_di_b <= mem_b[grad_addr_b[6:0]];

  // ---------------- scoreboard ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_mag [16];
  logic [23:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] pk(input int gx, input int gy);
    logic [31:0] x, y;
    x = gx;
    y = gy;
    return {x[9:0], y[9:0]};
  endfunction

  // Independent reference for DUT B contents
  function automatic int ref_m(input int i);
    int gx, gy;
    gx = (i - 64) * 8;
    gy = (i % 7) - 3;
    return ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
  endfunction

  // Hand-computed table: gradient word and expected saturated magnitude (9 edges)
  task automatic load_table1();
    mem_a[0]  = pk(3, -4);      exp_mag[0]  = 8'd7;
    mem_a[1]  = pk(-512, -512); exp_mag[1]  = 8'd255;
    mem_a[2]  = pk(0, 0);       exp_mag[2]  = 8'd0;
    mem_a[3]  = pk(511, 511);   exp_mag[3]  = 8'd255;
    mem_a[4]  = pk(-1, 1);      exp_mag[4]  = 8'd2;
    mem_a[5]  = pk(100, -27);   exp_mag[5]  = 8'd127;
    mem_a[6]  = pk(-200, 55);   exp_mag[6]  = 8'd255;
    mem_a[7]  = pk(128, 128);   exp_mag[7]  = 8'd255;
    mem_a[8]  = pk(-63, 0);     exp_mag[8]  = 8'd63;
    mem_a[9]  = pk(0, -64);     exp_mag[9]  = 8'd64;
    mem_a[10] = pk(255, 0);     exp_mag[10] = 8'd255;
    mem_a[11] = pk(-128, -127); exp_mag[11] = 8'd255;
    mem_a[12] = pk(10, 20);     exp_mag[12] = 8'd30;
    mem_a[13] = pk(-5, -6);     exp_mag[13] = 8'd11;
    mem_a[14] = pk(31, 32);     exp_mag[14] = 8'd63;
    mem_a[15] = pk(32, 32);     exp_mag[15] = 8'd64;
  endtask

  // Runs one frame on DUT A from IDLE/FIN; optional extra start pulse in cycle mid_start.
  task automatic run_a(input int mid_start, input logic [15:0] exp_edges);
    int          next_rd;
    int          first_done;
    logic [23:0] exp_w;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({16'(i), exp_mag[i]});
    next_rd = 0;
    first_done = -1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 1) begin
        vectors++;
        if ({edge_cnt_a, done_a, busy_a} !== {16'd0, 1'b0, 1'b1}) begin
          miscompares++;
          $display("FAIL start_clear: got cnt=%0d done=%b busy=%b, want cnt=0 done=0 busy=1",
                   edge_cnt_a, done_a, busy_a);
        end
      end
      if (grad_rd_a) begin
        vectors++;
        if (grad_addr_a !== 16'(next_rd) || next_rd >= 16) begin
          miscompares++;
          $display("FAIL rd_addr c=%0d: got %0d, want %0d", c, grad_addr_a, next_rd);
        end
        next_rd++;
      end
      if (mag_wr_a) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_write c=%0d: got addr %0d, want no write", c, mag_addr_a);
        end else begin
          exp_w = exp_q.pop_front();
          if ({mag_addr_a, mag_do_a} !== exp_w) begin
            miscompares++;
            $display("FAIL write c=%0d: got addr=%0d mag=%0d, want addr=%0d mag=%0d",
                     c, mag_addr_a, mag_do_a, exp_w[23:8], exp_w[7:0]);
          end
        end
      end
      if (done_a && first_done < 0) first_done = c;
      if (first_done >= 0) begin
        vectors++;
        if ({done_a, busy_a, grad_rd_a, mag_wr_a, edge_cnt_a} !== {4'b1000, exp_edges}) begin
          miscompares++;
          $display("FAIL done_hold c=%0d: got done=%b busy=%b rd=%b wr=%b cnt=%0d, want 1/0/0/0 cnt=%0d",
                   c, done_a, busy_a, grad_rd_a, mag_wr_a, edge_cnt_a, exp_edges);
        end
      end
      start_a = (c == mid_start);
      tick();
      start_a = 1'b0;
    end
    vectors++;
    if (next_rd != 16 || exp_q.size() != 0 || first_done != 19) begin
      miscompares++;
      $display("FAIL frame_total: got reads=%0d pending=%0d done_cycle=%0d, want 16/0/19",
               next_rd, exp_q.size(), first_done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_a = 1'b0; reset_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({grad_rd_a, grad_addr_a, mag_wr_a, mag_addr_a, mag_do_a, edge_cnt_a, busy_a, done_a} !== '0
          || state_a !== IDLE) begin
        miscompares++;
        $display("FAIL reset_a: got rd=%b ra=%0d wr=%b wa=%0d mag=%0d cnt=%0d busy=%b done=%b, want all 0",
                 grad_rd_a, grad_addr_a, mag_wr_a, mag_addr_a, mag_do_a, edge_cnt_a, busy_a, done_a);
      end
      vectors++;
      if ({grad_rd_b, grad_addr_b, mag_wr_b, mag_addr_b, mag_do_b, edge_cnt_b, busy_b, done_b} !== '0
          || state_b !== IDLE) begin
        miscompares++;
        $display("FAIL reset_b: got rd=%b ra=%0d wr=%b busy=%b done=%b, want all 0",
                 grad_rd_b, grad_addr_b, mag_wr_b, busy_b, done_b);
      end
      tick();
    end
    reset_a = 1'b1; reset_b = 1'b1;
    tick();
    vectors++;
    if ({grad_rd_a, busy_a, done_a} !== 3'b000 || state_a !== IDLE) begin
      miscompares++;
      $display("FAIL idle_no_start: got rd=%b busy=%b done=%b, want 0/0/0", grad_rd_a, busy_a, done_a);
    end
  endtask

  // NPIX=16, start sampled at the end of cycle 0, plus a start coincident with the final write
  task automatic test_timing();
    logic        e_rd, e_wr, e_busy, e_done;
    logic [15:0] e_ra, e_wa;
    load_table1();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      e_rd   = (c <= 16);
      e_ra   = (c <= 16) ? 16'(c - 1) : 16'd15;
      e_wr   = (c >= 3 && c <= 18);
      e_wa   = (c < 3) ? 16'd0 : ((c <= 18) ? 16'(c - 3) : 16'd15);
      e_busy = (c <= 18);
      e_done = (c >= 19);
      vectors++;
      if ({grad_rd_a, grad_addr_a, mag_wr_a, mag_addr_a, busy_a, done_a} !==
          {e_rd, e_ra, e_wr, e_wa, e_busy, e_done}) begin
        miscompares++;
        $display("FAIL timing c=%0d: got rd=%b ra=%0d wr=%b wa=%0d busy=%b done=%b, want %b/%0d/%b/%0d/%b/%b",
                 c, grad_rd_a, grad_addr_a, mag_wr_a, mag_addr_a, busy_a, done_a,
                 e_rd, e_ra, e_wr, e_wa, e_busy, e_done);
      end
      if (e_wr) begin
        vectors++;
        if (mag_do_a !== exp_mag[c-3]) begin
          miscompares++;
          $display("FAIL mag_do addr=%0d: got %0d, want %0d", c - 3, mag_do_a, exp_mag[c-3]);
        end
      end
      if (c >= 19) begin
        vectors++;
        if (edge_cnt_a !== 16'd9 || state_a !== FIN) begin
          miscompares++;
          $display("FAIL final_state c=%0d: got cnt=%0d state=%0d, want cnt=9 state=FIN",
                   c, edge_cnt_a, state_a);
        end
      end
      start_a = (c == 18);
      tick();
      start_a = 1'b0;
    end
  endtask

  // All pixels at THRESH-1 except ten at exactly THRESH
  task automatic test_threshold();
    logic [15:0] hit;
    hit = 16'hB55B;
    for (int i = 0; i < 16; i++) begin
      if (hit[i]) begin
        case (i % 3)
          0:       mem_a[i] = pk(-32, -32);
          1:       mem_a[i] = pk(64, 0);
          default: mem_a[i] = pk(-1, -63);
        endcase
        exp_mag[i] = 8'd64;
      end else begin
        case (i % 3)
          0:       mem_a[i] = pk(63, 0);
          1:       mem_a[i] = pk(-30, -33);
          default: mem_a[i] = pk(0, -63);
        endcase
        exp_mag[i] = 8'd63;
      end
    end
    run_a(0, 16'd10);
  endtask

  task automatic test_mid_start();
    load_table1();
    run_a(8, 16'd9);
  endtask

  task automatic test_back_to_back();
    run_a(0, 16'd9);
  endtask

  task automatic test_reset_mid();
    int          found;
    int          next_rd;
    int          first_done;
    int          exp_edges;
    int          m;
    logic [23:0] exp_w;
    for (int i = 0; i < 128; i++) mem_b[i] = pk((i - 64) * 8, (i % 7) - 3);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      if (grad_addr_b == 16'd100) found = 1;
      else tick();
    end
    vectors++;
    if (found == 0) begin
      miscompares++;
      $display("FAIL reach_pixel100: got addr=%0d, want 100 within budget", grad_addr_b);
    end
    reset_b = 1'b0;
    #1;
    vectors++;
    if ({grad_rd_b, grad_addr_b, mag_wr_b, mag_addr_b, mag_do_b, edge_cnt_b, busy_b, done_b} !== '0
        || state_b !== IDLE) begin
      miscompares++;
      $display("FAIL async_reset: got rd=%b ra=%0d wr=%b wa=%0d mag=%0d cnt=%0d busy=%b, want all 0",
               grad_rd_b, grad_addr_b, mag_wr_b, mag_addr_b, mag_do_b, edge_cnt_b, busy_b);
    end
    tick();
    tick();
    reset_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if ({grad_rd_b, mag_wr_b, busy_b, done_b} !== 4'b0000) begin
        miscompares++;
        $display("FAIL post_reset_quiet: got rd=%b wr=%b busy=%b done=%b, want 0000",
                 grad_rd_b, mag_wr_b, busy_b, done_b);
      end
    end
    exp_q.delete();
    exp_edges = 0;
    for (int i = 0; i < 128; i++) begin
      m = ref_m(i);
      if (m >= 64) exp_edges++;
      exp_q.push_back({16'(i), (m > 255) ? 8'd255 : 8'(m)});
    end
    next_rd = 0;
    first_done = -1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 140 && first_done < 0; c++) begin
      if (grad_rd_b) begin
        vectors++;
        if (grad_addr_b !== 16'(next_rd)) begin
          miscompares++;
          $display("FAIL b_rd_addr c=%0d: got %0d, want %0d", c, grad_addr_b, next_rd);
        end
        next_rd++;
      end
      if (mag_wr_b) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b_extra_write: got addr %0d, want none", mag_addr_b);
        end else begin
          exp_w = exp_q.pop_front();
          if ({mag_addr_b, mag_do_b} !== exp_w) begin
            miscompares++;
            $display("FAIL b_write: got addr=%0d mag=%0d, want addr=%0d mag=%0d",
                     mag_addr_b, mag_do_b, exp_w[23:8], exp_w[7:0]);
          end
        end
      end
      if (done_b) first_done = c;
      else tick();
    end
    vectors++;
    if (first_done != 131 || next_rd != 128 || exp_q.size() != 0 || edge_cnt_b !== 16'(exp_edges)) begin
      miscompares++;
      $display("FAIL b_frame: got done_cycle=%0d reads=%0d pending=%0d cnt=%0d, want 131/128/0/%0d",
               first_done, next_rd, exp_q.size(), edge_cnt_b, exp_edges);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_timing();
    test_threshold();
    test_mid_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, want finish earlier");
    $fatal(1, "timeout");
  end

endmodule
